// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial bit-pattern transmitter.
// Latches a WIDTH-bit pattern on start and shifts it out MSB-first, one bit
// per clk. The frame repeats repeat_count times (0 counts as 1), with GAP idle
// cycles between frames. The cycle that pulses frame_done is the first gap cycle.
// Optional feature macro: SEQGEN_PARITY_EN appends an even-parity bit cycle
// after the LSB of every frame.
module seq_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNTW-1:0]  repeat_count,
  output logic             out,
  output logic             busy,
  output logic             frame_done,
  output logic             done
);

  localparam int BCW = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH);
  localparam logic [7:0]     GAP_LAST = 8'(GAP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_PARITY,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;        // latched pattern, reused for every repeat
  logic [WIDTH-1:0] shreg_q, shreg_d;    // bits still to send, MSB next
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d; // bits already sent in this frame
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic [CNTW-1:0]  frames_q, frames_d;   // frames remaining, including the current one
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             done_q, done_d;
  logic             end_frame;

  // Next-state and next-output computation for the transmitter FSM
  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    frames_d     = frames_q;
    out_d        = 1'b0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    done_d       = 1'b0;
    end_frame    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d     = pattern;
          frames_d  = (repeat_count == '0) ? CNTW'(1) : repeat_count;
          out_d     = pattern[WIDTH-1];
          shreg_d   = pattern << 1;
          bit_cnt_d = BCW'(1);
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (bit_cnt_q != BIT_LAST) begin
          out_d     = shreg_q[WIDTH-1];
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else begin
`ifdef SEQGEN_PARITY_EN
          out_d   = ^pat_q;
          state_d = S_PARITY;
`else
          end_frame = 1'b1;
`endif
        end
      end

`ifdef SEQGEN_PARITY_EN
      S_PARITY: begin
        end_frame = 1'b1;
      end
`endif

      S_GAP: begin
        // gap_cnt counts gap cycles already shown; the frame_done cycle was number 1
        if (gap_cnt_q == GAP_LAST) begin
          out_d     = pat_q[WIDTH-1];
          shreg_d   = pat_q << 1;
          bit_cnt_d = BCW'(1);
          state_d   = S_SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (end_frame) begin
      frame_done_d = 1'b1;
      bit_cnt_d    = '0;
      if (frames_q == CNTW'(1)) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end else begin
        frames_d  = frames_q - CNTW'(1);
        gap_cnt_d = 8'd1;
        state_d   = S_GAP;
      end
    end
  end

  // State and registered outputs; reset aborts any transfer without pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pat_q        <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      frames_q     <= '0;
      out_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      frames_q     <= frames_d;
      out_q        <= out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      done_q       <= done_d;
    end
  end

  assign out        = out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Testbench for seq_pattern_gen (WIDTH=8, GAP=2). Each accepted start pushes the
// full per-cycle expected output list of the transaction into a queue; a
// monitor pops one entry per cycle and compares all four outputs.
module tb_seq_pattern_gen;

  localparam int WIDTH = 8;
  localparam int GAP   = 2;
  localparam int CNTW  = 8;
`ifdef SEQGEN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNTW-1:0]  repeat_count;
  logic             out;
  logic             busy;
  logic             frame_done;
  logic             done;

  // expected {out, busy, frame_done, done} for each upcoming cycle
  logic [3:0] exp_q[$];
  int         checks = 0;
  int         passed = 0;
  bit         mon_en = 1'b0;

  always #5 clk = ~clk;

  seq_pattern_gen #(.WIDTH(WIDTH), .GAP(GAP), .CNTW(CNTW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pattern      (pattern),
    .repeat_count (repeat_count),
    .out          (out),
    .busy         (busy),
    .frame_done   (frame_done),
    .done         (done)
  );

  // Reference: a transaction is n frames of bits, optional parity bit, then
  // either a gap of GAP cycles (first one flagged frame_done) or the done cycle.
  task automatic push_txn(input logic [WIDTH-1:0] p, input logic [CNTW-1:0] r);
    int n;
    n = (r == 0) ? 1 : int'(r);
    for (int f = 0; f < n; f++) begin
      for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back({p[i], 1'b1, 1'b0, 1'b0});
      if (PAR != 0) exp_q.push_back({^p, 1'b1, 1'b0, 1'b0});
      if (f == n - 1) begin
        exp_q.push_back(4'b0011);
      end else begin
        exp_q.push_back(4'b0110);
        for (int g = 1; g < GAP; g++) exp_q.push_back(4'b0100);
      end
    end
  endtask

  // One cycle of stimulus, applied at the falling edge
  task automatic drive(input logic st, input logic [WIDTH-1:0] pat,
                       input logic [CNTW-1:0] rp, input logic rs);
    @(negedge clk);
    reset        = rs;
    start        = st;
    pattern      = pat;
    repeat_count = rp;
    if (rs) exp_q.delete();
    else if (st && exp_q.size() == 0) push_txn(pat, rp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 8'($urandom), 1'b0);
  endtask

  // Monitor: one comparison per cycle, sampled 1 time unit after the edge
  initial begin
    logic [3:0] e;
    logic [3:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b0000;
        a = {out, busy, frame_done, done};
        checks++;
        if (a === e) passed++;
        else $display("FAIL cycle t=%0t {out,busy,frame_done,done} got %b expected %b",
                      $time, a, e);
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; pattern = '0; repeat_count = '0;
    drive(1'b0, 8'h00, 8'd0, 1'b1);
    drive(1'b0, 8'h00, 8'd0, 1'b1);
    mon_en = 1'b1;
    drive(1'b1, 8'h5A, 8'd2, 1'b1);   // start during reset must be ignored
    idle(3);

    // single frame, three frames, zero repeat
    drive(1'b1, 8'hA5, 8'd1, 1'b0); idle(12);
    drive(1'b1, 8'h81, 8'd3, 1'b0); idle(32);
    drive(1'b1, 8'hFF, 8'd0, 1'b0); idle(12);

    // ignored start mid-frame, then back-to-back start in the done cycle
    drive(1'b1, 8'hA5, 8'd1, 1'b0);
    idle(3);
    drive(1'b1, 8'h00, 8'd1, 1'b0);
    idle(4);
    drive(1'b1, 8'h3C, 8'd1, 1'b0);
    idle(14);

    // mid-frame reset, then a normal transfer
    drive(1'b1, 8'hA5, 8'd2, 1'b0);
    idle(3);
    drive(1'b0, 8'h00, 8'd0, 1'b1);
    idle(3);
    drive(1'b1, 8'h07, 8'd1, 1'b0); idle(12);

    // randomized traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      drive(($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom_range(0, 3)),
            ($urandom_range(0, 149) == 0));
    end

    // drain, bounded
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) idle(1);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expected cycles left, required 0", exp_q.size());
    end
    idle(3);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
